reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter ZERO_R0, default 0; when 1, register 0 reads as constant 16'h0000 and all writes to it are discarded.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 wr_valid  input  1  write request valid.
REQ-005 wr_ready  output  1  bank can accept a write this cycle.
REQ-006 wr_addr  input  4  destination register index 0..15.
REQ-007 wr_data  input  16  write data.
REQ-008 wr_be  input  2  byte enables; bit 0 = wr_data[7:0], bit 1 = wr_data[15:8].
REQ-009 clr_req  input  1  request a full-bank clear sweep.
REQ-010 clr_busy  output  1  clear sweep in progress.
REQ-011 q0..q15  output  16 each  current contents of registers 0..15; these feed the downstream 16:1 read-select mux data0..data15 in index order.

Function
REQ-012 Storage: sixteen 16-bit registers; q<n> SHALL be driven directly from register n with no combinational path from any input.
REQ-013 Write handshake: a write is accepted on a rising edge where wr_valid=1 and wr_ready=1; wr_valid without wr_ready is held off, not dropped by the bank.
REQ-014 Write latency: an accepted write SHALL be visible on q<wr_addr> in the cycle immediately after the accepting edge (1-cycle latency).
REQ-015 Byte merge: accepted write updates only enabled bytes; disabled bytes retain old value; wr_be=2'b00 completes the handshake with no register change.
REQ-016 wr_ready SHALL equal NOT clr_busy (derived from state register only, no dependence on wr_valid).
REQ-017 FSM has two states: IDLE and CLEAR, plus 4-bit sweep pointer ptr.
REQ-018 IDLE -> CLEAR on an edge with clr_req=1; ptr loaded with 0 on that edge.
REQ-019 In CLEAR, each edge zeroes register ptr and increments ptr; on the edge that clears register 15, state returns to IDLE and ptr wraps to 0.
REQ-020 A sweep SHALL last exactly 16 cycles; clr_busy=1 for exactly those 16 cycles.
REQ-021 clr_req asserted while in CLEAR SHALL be ignored (no restart, no extension).
REQ-022 Simultaneous clr_req=1 and accepted write in IDLE: the write commits on that edge, the sweep starts, and the written register is zeroed when ptr reaches it.
REQ-023 No writes are accepted in CLEAR; registers not yet reached by ptr retain their contents until cleared.
REQ-024 ZERO_R0=1: q0 constant 0 in all states; writes with wr_addr=0 complete the handshake and are discarded.
REQ-025 All arithmetic is unsigned; ptr increment wraps modulo 16.

Reset
REQ-026 On an edge with reset=1: all sixteen registers = 16'h0000, state = IDLE, ptr = 0.
REQ-027 Outputs in the cycle after reset: q0..q15 = 0, clr_busy = 0, wr_ready = 1.
REQ-028 Reset dominates: a simultaneous write or clr_req is discarded; reset during CLEAR aborts the sweep.

Verification
REQ-029 Post-reset: reset high 2 cycles -> q0..q15 = 0, wr_ready=1, clr_busy=0.
REQ-030 Byte write: write addr 5 data 16'hA5C3 be=11, then addr 5 data 16'h1200 be=10 -> q5 = 16'hA5C3 after first, 16'h12C3 after second, each 1 cycle after acceptance.
REQ-031 Clear sweep: load q0..q15 = 16'h1111*n style non-zero values, pulse clr_req 1 cycle -> clr_busy high exactly 16 cycles, wr_ready low same window, q<n> goes 0 in cycle n+1 after sweep start, all zero at end.
REQ-032 Write during clear: hold wr_valid=1 addr 3 data 16'hBEEF through sweep -> not accepted until clr_busy drops; q3 = 16'hBEEF one cycle after first IDLE edge.
REQ-033 Simultaneous: clr_req=1 with write addr 15 data 16'hFFFF in IDLE -> q15 = 16'hFFFF for 15 cycles, then 0 after 16th sweep edge.
REQ-034 Reset mid-sweep at cycle 8 -> all q = 0 next cycle, clr_busy=0, wr_ready=1; ZERO_R0=1 run: write addr 0 data 16'h7777 -> q0 stays 0.

Source files
------------

// File: rtl/reg_bank.sv
// Sixteen 16-bit registers with byte-enabled write port and a 16-cycle clear sweep.
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready; wr_ready depends only on state.
module reg_bank #(
  parameter int ZERO_R0 = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic [15:0] q0,
  output logic [15:0] q1,
  output logic [15:0] q2,
  output logic [15:0] q3,
  output logic [15:0] q4,
  output logic [15:0] q5,
  output logic [15:0] q6,
  output logic [15:0] q7,
  output logic [15:0] q8,
  output logic [15:0] q9,
  output logic [15:0] q10,
  output logic [15:0] q11,
  output logic [15:0] q12,
  output logic [15:0] q13,
  output logic [15:0] q14,
  output logic [15:0] q15,
  output logic [0:0]  dbg_state,
  output logic [3:0]  dbg_ptr
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [3:0]  ptr;
  logic [3:0]  ptr_nxt;
  logic [15:0] regs     [16];
  logic [15:0] regs_nxt [16];
  logic        wr_fire;

  assign wr_ready = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = 4'd0;
        end
      end
      CLEAR: begin
        // clr_req is deliberately not looked at here: a sweep cannot be restarted or extended
        ptr_nxt = ptr + 4'd1;
        if (ptr == 4'hF) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_nxt[i] = regs[i];
    end
    if (state == CLEAR) begin
      regs_nxt[ptr] = 16'h0000;
    end else if (wr_fire) begin
      if (wr_be[0]) regs_nxt[wr_addr][7:0]  = wr_data[7:0];
      if (wr_be[1]) regs_nxt[wr_addr][15:8] = wr_data[15:8];
    end
    // A hardwired-zero r0 swallows writes but still completes the handshake above
    if (ZERO_R0 != 0) begin
      regs_nxt[0] = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= regs_nxt[i];
      end
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

  assign q0  = regs[0];
  assign q1  = regs[1];
  assign q2  = regs[2];
  assign q3  = regs[3];
  assign q4  = regs[4];
  assign q5  = regs[5];
  assign q6  = regs[6];
  assign q7  = regs[7];
  assign q8  = regs[8];
  assign q9  = regs[9];
  assign q10 = regs[10];
  assign q11 = regs[11];
  assign q12 = regs[12];
  assign q13 = regs[13];
  assign q14 = regs[14];
  assign q15 = regs[15];

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: a default instance and a ZERO_R0=1 instance share one stimulus stream
// and are compared every cycle against an array-based model of the register bank.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [15:0] wr_data = 16'h0000;
  logic [1:0]  wr_be = 2'b00;
  logic        clr_req = 1'b0;

  logic [15:0] qa [16];
  logic [15:0] qb [16];
  logic        ready_a, ready_b, busy_a, busy_b;
  logic [0:0]  st_a, st_b;
  logic [3:0]  ptr_a, ptr_b;

  // model state
  logic [15:0] m [2][16];
  bit          m_busy;
  int          m_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank #(.ZERO_R0(0)) dut_a (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .clr_busy(busy_a),
    .q0(qa[0]), .q1(qa[1]), .q2(qa[2]), .q3(qa[3]),
    .q4(qa[4]), .q5(qa[5]), .q6(qa[6]), .q7(qa[7]),
    .q8(qa[8]), .q9(qa[9]), .q10(qa[10]), .q11(qa[11]),
    .q12(qa[12]), .q13(qa[13]), .q14(qa[14]), .q15(qa[15]),
    .dbg_state(st_a), .dbg_ptr(ptr_a)
  );

  reg_bank #(.ZERO_R0(1)) dut_b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(ready_b),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clr_req(clr_req), .clr_busy(busy_b),
    .q0(qb[0]), .q1(qb[1]), .q2(qb[2]), .q3(qb[3]),
    .q4(qb[4]), .q5(qb[5]), .q6(qb[6]), .q7(qb[7]),
    .q8(qb[8]), .q9(qb[9]), .q10(qb[10]), .q11(qb[11]),
    .q12(qb[12]), .q13(qb[13]), .q14(qb[14]), .q15(qb[15]),
    .dbg_state(st_b), .dbg_ptr(ptr_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies the bank's rules to the inputs present at the edge just taken.
  task automatic model_edge();
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 16; i++) m[b][i] = 16'h0000;
      m_busy = 0;
      m_idx  = 0;
    end else if (m_busy) begin
      for (int b = 0; b < 2; b++) m[b][m_idx] = 16'h0000;
      m_idx++;
      if (m_idx == 16) begin
        m_busy = 0;
        m_idx  = 0;
      end
    end else begin
      if (wr_valid) begin
        for (int b = 0; b < 2; b++) begin
          if (!(b == 1 && wr_addr == 4'd0)) begin
            if (wr_be[0]) m[b][wr_addr][7:0]  = wr_data[7:0];
            if (wr_be[1]) m[b][wr_addr][15:8] = wr_data[15:8];
          end
        end
      end
      if (clr_req) begin
        m_busy = 1;
        m_idx  = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s a.q%0d", tag, i), qa[i], m[0][i]);
      check($sformatf("%s b.q%0d", tag, i), qb[i], m[1][i]);
    end
    check({tag, " a.wr_ready"}, {15'd0, ready_a}, {15'd0, ~m_busy});
    check({tag, " b.wr_ready"}, {15'd0, ready_b}, {15'd0, ~m_busy});
    check({tag, " a.clr_busy"}, {15'd0, busy_a}, {15'd0, m_busy});
    check({tag, " b.clr_busy"}, {15'd0, busy_b}, {15'd0, m_busy});
    check({tag, " a.state"}, {15'd0, st_a}, {15'd0, m_busy});
    check({tag, " a.ptr"}, {12'd0, ptr_a}, 16'(m_idx));
  endtask

  task automatic step(input bit rst, input bit v, input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] be, input bit clr, input string tag);
    @(negedge clk);
    reset    = rst;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    clr_req  = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 4'd0, 16'h0000, 2'b00, 0, tag);
  endtask

  initial begin
    int busy_cnt;
    m_busy = 0;
    m_idx  = 0;

    // reset held two cycles
    step(1, 1, 4'd4, 16'h1234, 2'b11, 1, "reset1");
    step(1, 0, 4'd0, 16'h0000, 2'b00, 0, "reset2");
    idle("post_reset");

    // byte-merge writes
    step(0, 1, 4'd5, 16'hA5C3, 2'b11, 0, "bw_full");
    check("bw_full q5", qa[5], 16'hA5C3);
    step(0, 1, 4'd5, 16'h1200, 2'b10, 0, "bw_hi");
    check("bw_hi q5", qa[5], 16'h12C3);
    step(0, 1, 4'd5, 16'hFFFF, 2'b00, 0, "bw_none");
    check("bw_none q5", qa[5], 16'h12C3);
    step(0, 1, 4'd6, 16'hAB77, 2'b01, 0, "bw_lo");

    // load distinct values, then a one-cycle clear pulse; clr_req re-raised mid-sweep
    for (int n = 0; n < 16; n++)
      step(0, 1, 4'(n), 16'(16'h1111 * (n + 1)), 2'b11, 0, "load");
    step(0, 0, 4'd0, 16'h0000, 2'b00, 1, "clr_start");
    busy_cnt = busy_a ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 4'd0, 16'h0000, 2'b00, (k == 5 || k == 14), "sweep");
      if (busy_a) busy_cnt++;
    end
    check("sweep_len", 16'(busy_cnt), 16'd16);
    for (int i = 0; i < 16; i++) check("sweep_zero", qa[i], 16'h0000);

    // write held pending through a whole sweep
    step(0, 1, 4'd9, 16'h5A5A, 2'b11, 0, "pre_w");
    step(0, 0, 4'd0, 16'h0000, 2'b00, 1, "clr_w");
    for (int k = 0; k < 18; k++)
      step(0, 1, 4'd3, 16'hBEEF, 2'b11, 0, "held_w");
    check("held_w q3", qa[3], 16'hBEEF);

    // write and clear on the same edge
    step(0, 1, 4'd15, 16'hFFFF, 2'b11, 1, "simul");
    for (int k = 0; k < 15; k++) begin
      idle("simul_sweep");
      check("simul q15 kept", qa[15], 16'hFFFF);
    end
    idle("simul_end");
    check("simul q15 zeroed", qa[15], 16'h0000);

    // reset aborting a sweep part-way
    for (int n = 0; n < 16; n++)
      step(0, 1, 4'(n), 16'(16'hC000 + n), 2'b11, 0, "reload");
    step(0, 0, 4'd0, 16'h0000, 2'b00, 1, "clr_abort");
    for (int k = 0; k < 7; k++) idle("pre_abort");
    step(1, 0, 4'd0, 16'h0000, 2'b00, 0, "abort_reset");
    check("abort busy", {15'd0, busy_a}, 16'd0);
    check("abort q15", qa[15], 16'h0000);

    // register 0 write on both instances
    step(0, 1, 4'd0, 16'h7777, 2'b11, 0, "r0_write");
    check("r0 zero_r0", qb[0], 16'h0000);
    check("r0 normal", qa[0], 16'h7777);
    check("r0 ready", {15'd0, ready_b}, 16'd1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
